axi4_mem_target: RTL and testbench

// - Simulation/verification AXI4 slave memory model standing in for the DDR4 controller behind
//   the external-memory traffic generator.
// - Accepts INCR write and read bursts of full-width 512-bit beats.
// - Stores data in an internal array, returns it on reads.
// - Write and read channels are independent; each handles one burst at a time.

---
 rtl/axi4_mem_target.sv | 228 ++++++++++++++++++++++
 tb/tb_axi4_mem_target.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mem_target.sv
`default_nettype none
// ============================================================================
// Module   : axi4_mem_target
// Purpose  : AXI4 slave memory model. Accepts INCR bursts of full-width
//            beats on independent write and read channels, one burst at a
//            time per channel, backed by an internal beat-addressed array.
// Revision : 1.0  initial release
// ============================================================================
module axi4_mem_target #(
    parameter int DATA_WIDTH     = 512,
    parameter int ID_WIDTH       = 4,
    parameter int MEM_ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             AWADDR,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [7:0]              AWLEN,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ID_WIDTH-1:0]     WID,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [31:0]             ARADDR,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [7:0]              ARLEN,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int C_STRB_W = DATA_WIDTH / 8;
    localparam int C_DEPTH  = 1 << MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    logic [DATA_WIDTH-1:0] mem [C_DEPTH];

    wstate_t                   wstate_q;
    logic                      awready_q;
    logic                      wready_q;
    logic                      bvalid_q;
    logic [ID_WIDTH-1:0]       bid_q;
    logic [1:0]                bresp_q;
    logic [MEM_ADDR_WIDTH-1:0] widx_q;
    logic [7:0]                wlen_q;
    logic [7:0]                wcnt_q;
    logic                      werr_q;

    rstate_t                   rstate_q;
    logic                      arready_q;
    logic                      rvalid_q;
    logic                      rlast_q;
    logic [ID_WIDTH-1:0]       rid_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [MEM_ADDR_WIDTH-1:0] ridx_q;
    logic [7:0]                rlen_q;
    logic [7:0]                rcnt_q;

    logic                      w_wr_en;
    logic                      w_wfinal;
    logic                      w_err_d;
    logic [MEM_ADDR_WIDTH-1:0] w_ar_idx;
    logic [7:0]                w_rcnt_nxt;
    logic                      w_unused;

    // Beat write enable and protocol error detection for the current beat:
    // WLAST must coincide exactly with the final beat of the burst.
    assign w_wr_en    = (wstate_q == W_DATA) && wready_q && WVALID;
    assign w_wfinal   = (wcnt_q == wlen_q);
    assign w_err_d    = werr_q | (WLAST != w_wfinal);
    assign w_ar_idx   = ARADDR[6 +: MEM_ADDR_WIDTH];
    assign w_rcnt_nxt = rcnt_q + 8'd1;

    // Byte-lane and upper address bits carry no meaning for this model.
    assign w_unused = ^{WID, AWADDR[31:6+MEM_ADDR_WIDTH], AWADDR[5:0],
                        ARADDR[31:6+MEM_ADDR_WIDTH], ARADDR[5:0]};

    // Storage is not reset; only strobed bytes of an accepted beat are updated.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < C_STRB_W; b++) begin
                if (WSTRB[b]) begin
                    mem[widx_q][b*8 +: 8] <= WDATA[b*8 +: 8];
                end
            end
        end
    end

    // Write channel FSM: address capture, data beats, then buffered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'b00;
            widx_q    <= '0;
            wlen_q    <= 8'd0;
            wcnt_q    <= 8'd0;
            werr_q    <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (AWVALID && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        widx_q    <= AWADDR[6 +: MEM_ADDR_WIDTH];
                        bid_q     <= AWID;
                        wlen_q    <= AWLEN;
                        wcnt_q    <= 8'd0;
                        werr_q    <= 1'b0;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (WVALID) begin
                        widx_q <= widx_q + MEM_ADDR_WIDTH'(1);
                        wcnt_q <= wcnt_q + 8'd1;
                        werr_q <= w_err_d;
                        // Burst length, not WLAST, decides when the burst ends.
                        if (w_wfinal) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= w_err_d ? 2'b10 : 2'b00;
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= 2'b00;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: prefetch first beat on AR, advance one beat per handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            ridx_q    <= '0;
            rlen_q    <= 8'd0;
            rcnt_q    <= 8'd0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ARVALID && arready_q) begin
                        arready_q <= 1'b0;
                        rdata_q   <= mem[w_ar_idx];
                        ridx_q    <= w_ar_idx + MEM_ADDR_WIDTH'(1);
                        rid_q     <= ARID;
                        rlen_q    <= ARLEN;
                        rcnt_q    <= 8'd0;
                        rlast_q   <= (ARLEN == 8'd0);
                        rvalid_q  <= 1'b1;
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    // RVALID is always high here, so RREADY alone completes a beat.
                    if (RREADY) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            rdata_q <= mem[ridx_q];
                            ridx_q  <= ridx_q + MEM_ADDR_WIDTH'(1);
                            rcnt_q  <= w_rcnt_nxt;
                            rlast_q <= (w_rcnt_nxt == rlen_q);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_axi4_mem_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_mem_target
// Purpose  : Directed self-checking bench for axi4_mem_target with a byte-
//            level reference memory and a read-beat scoreboard queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi4_mem_target;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  AWADDR;
    logic [3:0]   AWID;
    logic [7:0]   AWLEN;
    logic         AWVALID;
    logic         AWREADY;
    logic [3:0]   WID;
    logic [511:0] WDATA;
    logic [63:0]  WSTRB;
    logic         WLAST;
    logic         WVALID;
    logic         WREADY;
    logic [3:0]   BID;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [31:0]  ARADDR;
    logic [3:0]   ARID;
    logic [7:0]   ARLEN;
    logic         ARVALID;
    logic         ARREADY;
    logic [3:0]   RID;
    logic [511:0] RDATA;
    logic [1:0]   RRESP;
    logic         RLAST;
    logic         RVALID;
    logic         RREADY;

    int vectors     = 0;
    int miscompares = 0;

    logic [511:0] model [int];
    logic [511:0] exp_data_q [$];
    logic         exp_last_q [$];

    axi4_mem_target #(
        .DATA_WIDTH    (512),
        .ID_WIDTH      (4),
        .MEM_ADDR_WIDTH(16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .AWADDR (AWADDR),
        .AWID   (AWID),
        .AWLEN  (AWLEN),
        .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .WID    (WID),
        .WDATA  (WDATA),
        .WSTRB  (WSTRB),
        .WLAST  (WLAST),
        .WVALID (WVALID),
        .WREADY (WREADY),
        .BID    (BID),
        .BRESP  (BRESP),
        .BVALID (BVALID),
        .BREADY (BREADY),
        .ARADDR (ARADDR),
        .ARID   (ARID),
        .ARLEN  (ARLEN),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RID    (RID),
        .RDATA  (RDATA),
        .RRESP  (RRESP),
        .RLAST  (RLAST),
        .RVALID (RVALID),
        .RREADY (RREADY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int beat_idx(input logic [31:0] addr);
        return int'(addr[21:6]);
    endfunction

    // Write burst; beat k carries base+k. WLAST is driven on beat lastpos.
    task automatic write_burst(input logic [31:0] addr, input logic [3:0] id,
                               input logic [7:0] len, input logic [511:0] base,
                               input logic [63:0] strb, input int lastpos,
                               input logic [1:0] exp_resp, input int bdelay);
        int n;
        int idx;
        AWADDR = addr; AWID = id; AWLEN = len; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin @(negedge clk); n++; end
        chk("aw_ready", AWREADY, 1);
        @(negedge clk);
        AWVALID = 1'b0;
        idx = beat_idx(addr);
        for (int k = 0; k <= int'(len); k++) begin
            WVALID = 1'b1; WDATA = base + 512'(k); WSTRB = strb; WLAST = (k == lastpos);
            n = 0;
            while (!WREADY && n < 50) begin @(negedge clk); n++; end
            chk("w_ready", WREADY, 1);
            if (!model.exists(idx)) model[idx] = '0;
            for (int b = 0; b < 64; b++)
                if (strb[b]) model[idx][b*8 +: 8] = WDATA[b*8 +: 8];
            idx = (idx + 1) & 16'hFFFF;
            @(negedge clk);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        n = 0;
        while (!BVALID && n < 50) begin @(negedge clk); n++; end
        chk("b_valid", BVALID, 1);
        chk("b_id", BID, id);
        chk("b_resp", BRESP, exp_resp);
        for (int d = 0; d < bdelay; d++) begin
            chk("b_hold_valid", BVALID, 1);
            chk("b_hold_id", BID, id);
            chk("b_hold_awready", AWREADY, 0);
            @(negedge clk);
        end
        BREADY = 1'b1;
        @(negedge clk);
        BREADY = 1'b0;
        chk("b_drop", BVALID, 0);
    endtask

    // Read burst; expected beats come from the model. abort_at >= 0 asserts
    // reset after that many beats have been accepted.
    task automatic read_burst(input logic [31:0] addr, input logic [3:0] id,
                              input logic [7:0] len, input bit toggle, input int abort_at);
        int n;
        int idx;
        int got;
        bit rr;
        idx = beat_idx(addr);
        for (int k = 0; k <= int'(len); k++) begin
            exp_data_q.push_back(model.exists(idx) ? model[idx] : '0);
            exp_last_q.push_back(k == int'(len));
            idx = (idx + 1) & 16'hFFFF;
        end
        ARADDR = addr; ARID = id; ARLEN = len; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin @(negedge clk); n++; end
        chk("ar_ready", ARREADY, 1);
        @(negedge clk);
        ARVALID = 1'b0;
        got = 0; n = 0; rr = 1'b0;
        while (got <= int'(len) && n < 600) begin
            if (abort_at >= 0 && got == abort_at) break;
            RREADY = toggle ? rr : 1'b1;
            rr = !rr;
            if (RVALID) begin
                chk("r_data", RDATA, exp_data_q[0]);
                chk("r_last", RLAST, exp_last_q[0]);
                chk("r_id", RID, id);
                chk("r_resp", RRESP, 2'b00);
                if (RREADY) begin
                    void'(exp_data_q.pop_front());
                    void'(exp_last_q.pop_front());
                    got++;
                end
            end else if (!toggle) begin
                chk("r_b2b_valid", RVALID, 1);
            end
            @(negedge clk);
            n++;
        end
        RREADY = 1'b0;
        if (abort_at < 0) begin
            chk("r_beats", got, int'(len) + 1);
            chk("r_valid_drop", RVALID, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        AWADDR = '0; AWID = '0; AWLEN = '0; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0;
        ARADDR = '0; ARID = '0; ARLEN = '0; ARVALID = 1'b0;
        RREADY = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_rdata", RDATA, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_awready", AWREADY, 1);
        chk("post_rst_arready", ARREADY, 1);

        // Single beat
        write_burst(32'h40, 4'h3, 8'd0, {64{8'hA5}}, '1, 0, 2'b00, 0);
        read_burst(32'h40, 4'h5, 8'd0, 1'b0, -1);

        // 64-beat burst, beat k = k
        write_burst(32'h1000, 4'h7, 8'd63, '0, '1, 63, 2'b00, 0);
        read_burst(32'h1000, 4'h9, 8'd63, 1'b0, -1);

        // Byte strobes
        write_burst(32'h80, 4'h1, 8'd0, '1, '1, 0, 2'b00, 0);
        write_burst(32'h80, 4'h2, 8'd0, '0, 64'hF, 0, 2'b00, 0);
        read_burst(32'h80, 4'h2, 8'd0, 1'b0, -1);

        // Read backpressure and write-response backpressure
        read_burst(32'h1000, 4'hA, 8'd15, 1'b1, -1);
        write_burst(32'h3000, 4'hC, 8'd1, {16{32'hDEAD_BEEF}}, '1, 1, 2'b00, 10);
        read_burst(32'h3000, 4'hC, 8'd1, 1'b1, -1);

        // Early WLAST: burst still runs 4 beats, then SLVERR
        write_burst(32'h4000, 4'hE, 8'd3, {16{32'h1234_5678}}, '1, 2, 2'b10, 0);
        read_burst(32'h4000, 4'hE, 8'd3, 1'b0, -1);
        // Missing WLAST on final beat
        write_burst(32'h5000, 4'h4, 8'd1, {16{32'h0BAD_F00D}}, '1, -1, 2'b10, 0);

        // Address wrap; upper address bits ignored on the read back
        write_burst(32'h003F_FFC0, 4'h6, 8'd1, {16{32'hCAFE_0000}}, '1, 1, 2'b00, 0);
        read_burst(32'h0040_0000, 4'h6, 8'd0, 1'b0, -1);
        read_burst(32'h003F_FFC0, 4'h6, 8'd1, 1'b0, -1);

        // Reset in the middle of a read burst
        read_burst(32'h1000, 4'hB, 8'd15, 1'b0, 3);
        reset = 1'b1;
        #1;
        chk("abort_rvalid", RVALID, 0);
        chk("abort_arready", ARREADY, 0);
        exp_data_q.delete();
        exp_last_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rel_awready", AWREADY, 1);
        chk("abort_rel_arready", ARREADY, 1);
        chk("abort_rel_rvalid", RVALID, 0);
        write_burst(32'h2000, 4'hD, 8'd3, {16{32'h5555_AAAA}}, '1, 3, 2'b00, 0);
        read_burst(32'h2000, 4'hD, 8'd3, 1'b0, -1);
        // Earlier burst data survives the reset
        read_burst(32'h1000, 4'h8, 8'd3, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
